// File: rtl/pc_pkg.sv
// Op encoding for the program counter, shared by the counter and its bench.
// The priority encoder lives here so the ordering is fixed in one place.
package pc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_BRANCH,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Ret > Call > Load > Branch > Up > hold; the caller masks Ret when no stack exists.
    function automatic pc_op_e pc_encode(input logic ret, input logic call, input logic load,
                                         input logic branch, input logic up);
        if (ret)         return PC_RET;
        else if (call)   return PC_CALL;
        else if (load)   return PC_LOAD;
        else if (branch) return PC_BRANCH;
        else if (up)     return PC_INC;
        else             return PC_HOLD;
    endfunction

endpackage

// File: rtl/prog_counter_ctl_if.sv
// Request/status bundle between the control FSM (master) and the program counter (slave).
// Requests are level-sampled each Clock edge; there is no handshake or backpressure.
interface prog_counter_ctl_if #(parameter int AW = 7);

    logic          En;
    logic          Up;
    logic          Load;
    logic [AW-1:0] LoadAddr;
    logic          Branch;
    logic [AW-1:0] Offset;
    logic          Call;
    logic          Ret;
    logic [AW-1:0] Q;
    logic [AW-1:0] QPlus1;
    logic          Wrap;
    logic          RasFull;
    logic          RasEmpty;
    logic          RasErr;

    modport master (
        output En, Up, Load, LoadAddr, Branch, Offset, Call, Ret,
        input  Q, QPlus1, Wrap, RasFull, RasEmpty, RasErr
    );

    modport slave (
        input  En, Up, Load, LoadAddr, Branch, Offset, Call, Ret,
        output Q, QPlus1, Wrap, RasFull, RasEmpty, RasErr
    );

endinterface

// File: rtl/pc_ras_stack.sv
// Circular return-address stack: push when full overwrites the oldest entry, pop when empty is refused; both set a sticky Err.
// One-cycle update; DOut shows the current top combinationally; no backpressure (errors are flagged, never stalled).
module pc_ras_stack #(
    parameter int AW        = 7,
    parameter int RAS_DEPTH = 4
) (
    input  logic          Clock,
    input  logic          Clear_n,
    input  logic          Push,
    input  logic          Pop,
    input  logic [AW-1:0] DIn,
    output logic [AW-1:0] DOut,
    output logic          Full,
    output logic          Empty,
    output logic          Err
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

    logic [AW-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] wp;
    logic [PW:0]   cnt;
    logic          err_r;

    // Storage is not reset: a cleared stack is empty, so stale entries are unreachable.
    always_ff @(posedge Clock) begin
        if (Clear_n && Push)
            mem[wp] <= DIn;
    end

    always_ff @(posedge Clock) begin
        if (!Clear_n) begin
            wp    <= '0;
            cnt   <= '0;
            err_r <= 1'b0;
        end else if (Push) begin
            wp <= wp + 1'b1;
            if (cnt == DEPTH_C) err_r <= 1'b1;
            else                cnt   <= cnt + 1'b1;
        end else if (Pop) begin
            if (cnt == '0) begin
                err_r <= 1'b1;
            end else begin
                wp  <= wp - 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign DOut  = mem[wp - 1'b1];
    assign Full  = (cnt == DEPTH_C);
    assign Empty = (cnt == '0);
    assign Err   = err_r;

endmodule

// File: rtl/prog_counter_ctl.sv
// Program counter with stall, load, relative branch and (PC_RAS_EN) call/return stack; Q is registered, QPlus1 combinational.
// One-cycle latency from request to Q; En=0 stalls all state, no other backpressure.
module prog_counter_ctl
    import pc_pkg::*;
#(
    parameter int            AW        = 7,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int unsigned   STEP      = 1,
    parameter int            RAS_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Clear_n,
    prog_counter_ctl_if.slave bus
);

    localparam logic [AW:0] STEP_X = (AW+1)'(STEP);

    logic [AW-1:0] q_r, next_q;
    logic          wrap_r, next_wrap;
    logic [AW:0]   inc_sum;
    logic [AW-1:0] ras_top;
    logic          ras_empty;
    logic          ret_req;
    pc_op_e        op;

    assign inc_sum = {1'b0, q_r} + STEP_X;

`ifdef PC_RAS_EN
    logic ras_full, ras_err;

    assign ret_req = bus.Ret;

    pc_ras_stack #(.AW(AW), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .Clock   (Clock),
        .Clear_n (Clear_n),
        .Push    (bus.En && (op == PC_CALL)),
        .Pop     (bus.En && (op == PC_RET)),
        .DIn     (inc_sum[AW-1:0]),
        .DOut    (ras_top),
        .Full    (ras_full),
        .Empty   (ras_empty),
        .Err     (ras_err)
    );

    assign bus.RasFull  = ras_full;
    assign bus.RasEmpty = ras_empty;
    assign bus.RasErr   = ras_err;
`else
    // Without a stack Ret drops out of the encoder and Call degenerates to Load.
    assign ret_req      = 1'b0;
    assign ras_top      = q_r;
    assign ras_empty    = 1'b1;
    assign bus.RasFull  = 1'b0;
    assign bus.RasEmpty = 1'b1;
    assign bus.RasErr   = 1'b0;
`endif

    assign op = pc_encode(ret_req, bus.Call, bus.Load, bus.Branch, bus.Up);

    always_comb begin
        next_q    = q_r;
        next_wrap = 1'b0;
        if (bus.En) begin
            case (op)
                PC_RET:           next_q = ras_empty ? q_r : ras_top;
                PC_CALL, PC_LOAD: next_q = bus.LoadAddr;
                PC_BRANCH:        next_q = q_r + bus.Offset;
                PC_INC: begin
                    next_q    = inc_sum[AW-1:0];
                    next_wrap = inc_sum[AW];
                end
                default:          next_q = q_r;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Clear_n) begin
            q_r    <= RESET_VEC;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= next_q;
            wrap_r <= next_wrap;
        end
    end

    assign bus.Q      = q_r;
    assign bus.QPlus1 = inc_sum[AW-1:0];
    assign bus.Wrap   = wrap_r;

endmodule

// File: tb/tb_prog_counter_ctl.sv
// Directed plan plus randomized traffic against a queue-based reference of the counter and return stack.
module tb_prog_counter_ctl;

    localparam int AW    = 7;
    localparam int M     = 1 << AW;
    localparam int STEP  = 1;
    localparam int DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Clear_n;
    always #5 Clock = ~Clock;

    prog_counter_ctl_if #(.AW(AW)) bus ();

    prog_counter_ctl #(.AW(AW), .RESET_VEC('0), .STEP(STEP), .RAS_DEPTH(DEPTH)) dut (
        .Clock   (Clock),
        .Clear_n (Clear_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    int q_m;
    bit wrap_m;
    bit err_m;
    int stk[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Q"},        32'(bus.Q),        32'(q_m));
        chk({tag, ".QPlus1"},   32'(bus.QPlus1),   32'((q_m + STEP) % M));
        chk({tag, ".Wrap"},     32'(bus.Wrap),     32'(wrap_m));
        chk({tag, ".RasFull"},  32'(bus.RasFull),  32'(RAS && stk.size() == DEPTH));
        chk({tag, ".RasEmpty"}, 32'(bus.RasEmpty), 32'(!RAS || stk.size() == 0));
        chk({tag, ".RasErr"},   32'(bus.RasErr),   32'(err_m));
    endtask

    // Reference: the op chosen by priority, applied with plain modular arithmetic.
    task automatic model(input bit clr, input bit en, input bit up, input bit load, input int la,
                         input bit branch, input int off, input bit call, input bit ret);
        if (!clr) begin
            q_m = 0; wrap_m = 0; err_m = 0; stk.delete();
        end else if (!en) begin
            wrap_m = 0;
        end else begin
            wrap_m = 0;
            if (RAS && ret) begin
                if (stk.size() == 0) err_m = 1;
                else q_m = stk.pop_back();
            end else if (call) begin
                if (RAS) begin
                    if (stk.size() == DEPTH) begin
                        void'(stk.pop_front());
                        err_m = 1;
                    end
                    stk.push_back((q_m + STEP) % M);
                end
                q_m = la;
            end else if (load) begin
                q_m = la;
            end else if (branch) begin
                q_m = (q_m + off) % M;
            end else if (up) begin
                wrap_m = (q_m + STEP) >= M;
                q_m = (q_m + STEP) % M;
            end
        end
    endtask

    task automatic cyc(input string tag, input bit clr, input bit en, input bit up, input bit load,
                       input int la, input bit branch, input int off, input bit call, input bit ret);
        Clear_n      = clr;
        bus.En       = en;
        bus.Up       = up;
        bus.Load     = load;
        bus.LoadAddr = AW'(la);
        bus.Branch   = branch;
        bus.Offset   = AW'(off);
        bus.Call     = call;
        bus.Ret      = ret;
        @(posedge Clock);
        model(clr, en, up, load, la, branch, off, call, ret);
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input int a);
        cyc("load", 1, 1, 0, 1, a, 0, 0, 0, 0);
    endtask

    initial begin
        q_m = 0; wrap_m = 0; err_m = 0;
        Clear_n = 0; bus.En = 0; bus.Up = 0; bus.Load = 0; bus.LoadAddr = '0;
        bus.Branch = 0; bus.Offset = '0; bus.Call = 0; bus.Ret = 0;

        // Reset dominates Up and a stall.
        cyc("rst0", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_q_const", 32'(bus.Q), 32'd0);
        for (int i = 0; i < 3; i++) cyc("hold", 1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Increment across the top of the address space.
        do_load(126);
        cyc("inc127", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("inc127_wrap", 32'(bus.Wrap), 32'd0);
        cyc("inc0", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("inc0_q", 32'(bus.Q), 32'd0);
        chk("inc0_wrap", 32'(bus.Wrap), 32'd1);
        cyc("inc1", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("inc1_wrap", 32'(bus.Wrap), 32'd0);

        // Stall and priority.
        do_load(10);
        cyc("stall", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("stall_q", 32'(bus.Q), 32'd10);
        cyc("prio", 1, 1, 1, 1, 50, 1, 3, 0, 0);
        chk("prio_q", 32'(bus.Q), 32'd50);
        cyc("brneg", 1, 1, 0, 0, 0, 1, 'h7E, 0, 0);
        chk("brneg_q", 32'(bus.Q), 32'd48);
        do_load(120);
        cyc("brwrap", 1, 1, 0, 0, 0, 1, 20, 0, 0);
        chk("brwrap_nowrap", 32'(bus.Wrap), 32'd0);

        // Call/return: pushes the return address when a stack exists, acts as Load otherwise.
        do_load(20);
        cyc("call", 1, 1, 0, 0, 100, 0, 0, 1, 0);
        chk("call_q", 32'(bus.Q), 32'd100);
        cyc("callup", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc("ret_up", 1, 1, 1, 0, 0, 0, 0, 0, 1);
        chk("ret_up_q", 32'(bus.Q), RAS ? 32'd21 : 32'd102);

        // Overflow then underflow of the stack.
        for (int i = 0; i < 5; i++) begin
            do_load(i * 10);
            cyc("ovf_call", 1, 1, 0, 0, i * 10 + 10, 0, 0, 1, 0);
        end
        for (int i = 0; i < 5; i++) cyc("unf_ret", 1, 1, 0, 0, 0, 0, 0, 0, 1);
        cyc("ret_call", 1, 1, 0, 0, 77, 0, 0, 1, 1);
        cyc("errhold", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("rst_mid", 0, 1, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_mid_err", 32'(bus.RasErr), 32'd0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            cyc("rand",
                $urandom_range(0, 60) != 0,
                $urandom_range(0, 7) != 0,
                $urandom_range(0, 1) == 0,
                $urandom_range(0, 5) == 0,
                int'($urandom_range(0, M - 1)),
                $urandom_range(0, 4) == 0,
                int'($urandom_range(0, M - 1)),
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
